// File: rtl/request_encoder.sv
// Walks a multi-hot request vector and emits the index of each set bit, one per beat.
// Define REQUEST_ENCODER_MSB_FIRST_EN to drain from the highest set bit down instead of the lowest up.
module request_encoder #(
    parameter int INDEX_WIDTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [(1<<INDEX_WIDTH)-1:0] in_vec,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [INDEX_WIDTH-1:0]      out_idx,
    output logic                        out_last
);

    localparam int VEC_WIDTH = 1 << INDEX_WIDTH;

    typedef enum logic {
        IDLE,
        DRAIN
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [VEC_WIDTH-1:0]   pending_q;
    logic [VEC_WIDTH-1:0]   pending_d;
    logic [INDEX_WIDTH-1:0] sel_idx;
    logic                   single_bit;
    logic [VEC_WIDTH-1:0]   clear_mask;

    // Priority encode: the last match written wins, so scan order sets the drain direction.
    always_comb begin
        sel_idx = '0;
`ifdef REQUEST_ENCODER_MSB_FIRST_EN
        for (int i = 0; i < VEC_WIDTH; i++) begin
            if (pending_q[i]) begin
                sel_idx = INDEX_WIDTH'(i);
            end
        end
`else
        for (int i = VEC_WIDTH - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                sel_idx = INDEX_WIDTH'(i);
            end
        end
`endif
    end

    assign single_bit = (pending_q != '0) &&
                        ((pending_q & (pending_q - VEC_WIDTH'(1))) == '0);
    assign clear_mask = VEC_WIDTH'(1) << sel_idx;

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_idx   = '0;
        out_last  = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    pending_d = in_vec;
                    if (in_vec != '0) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                out_idx   = sel_idx;
                out_last  = single_bit;
                if (out_ready) begin
                    pending_d = pending_q & ~clear_mask;
                    if (single_bit) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

endmodule

// File: tb/tb_request_encoder.sv
// Scoreboard bench for request_encoder: a reference model queues expected beats per accepted vector,
// and a monitor pops and compares them as the DUT hands each beat over.
module tb_request_encoder;

    localparam int IW = 4;
    localparam int VW = 1 << IW;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic          last;
    } beat_t;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [VW-1:0] in_vec;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_idx;
    logic          out_last;

    beat_t sb[$];
    int    check_count;
    int    fail_count;
    int    beat_count;
    int    cycles;

    request_encoder #(.INDEX_WIDTH(IW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_vec   (in_vec),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_idx  (out_idx),
        .out_last (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Reference model: drain order follows the build's priority direction.
    task automatic pushModel(input logic [VW-1:0] vec);
        int total;
        int seen;
        int b;
        total = 0;
        seen  = 0;
        for (int i = 0; i < VW; i++) begin
            if (vec[i]) total++;
        end
        for (int i = 0; i < VW; i++) begin
`ifdef REQUEST_ENCODER_MSB_FIRST_EN
            b = VW - 1 - i;
`else
            b = i;
`endif
            if (vec[b]) begin
                seen++;
                sb.push_back('{idx: IW'(b), last: (seen == total)});
            end
        end
    endtask

    // Offer one vector, wait for the accepting edge, and confirm the one-cycle output latency.
    task automatic applyStimulus(input logic [VW-1:0] vec);
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) checkOutput("accept_timeout", 32'(in_ready), 32'd1);
        pushModel(vec);
        in_valid = 1'b1;
        in_vec   = vec;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput("latency_valid", 32'(out_valid), 32'(vec != '0));
    endtask

    task automatic waitIdle(input int max_cycles, output int n);
        n = 0;
        while (!(in_ready && sb.size() == 0) && n < max_cycles) begin
            @(posedge clk); #1;
            n++;
        end
        if (!(in_ready && sb.size() == 0)) checkOutput("idle_timeout", 32'(sb.size()), 32'd0);
    endtask

    // Monitor: a beat is handed over at the next rising edge when valid and ready are both high.
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("in_ready_vs_state", 32'(in_ready), 32'(!out_valid));
            if (!out_valid) begin
                checkOutput("idle_idx", 32'(out_idx), 32'd0);
            end
            if (out_valid && out_ready) begin
                beat_count++;
                if (sb.size() == 0) begin
                    checkOutput("unexpected_beat", 32'(out_idx), 32'hFFFF);
                end else begin
                    checkOutput("beat_idx", 32'(out_idx), 32'(sb[0].idx));
                    checkOutput("beat_last", 32'(out_last), 32'(sb[0].last));
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        int base;
        int n;
        check_count = 0;
        fail_count  = 0;
        beat_count  = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_vec      = '0;
        out_ready   = 1'b1;

        #1;
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_out_idx", 32'(out_idx), 32'd0);
        checkOutput("reset_out_last", 32'(out_last), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Empty vector is consumed silently.
        applyStimulus(16'h0000);
        for (int i = 0; i < 5; i++) begin
            checkOutput("zero_out_valid", 32'(out_valid), 32'd0);
            checkOutput("zero_in_ready", 32'(in_ready), 32'd1);
            @(posedge clk); #1;
        end

        // Four spread bits, consumer always ready: N+1 cycles to the next in_ready.
        applyStimulus(16'h8421);
        waitIdle(50, cycles);
        checkOutput("8421_drain_cycles", 32'(cycles), 32'd4);

        // Backpressure: the first beat must hold steady while out_ready is low.
        out_ready = 1'b0;
        applyStimulus(16'h0003);
        for (int i = 0; i < 3; i++) begin
            checkOutput("hold_valid", 32'(out_valid), 32'd1);
            checkOutput("hold_idx", 32'(out_idx), 32'(sb[0].idx));
            checkOutput("hold_last", 32'(out_last), 32'(sb[0].last));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        waitIdle(50, cycles);

        // Single-bit vectors round-trip through the decoder relation idx -> 1<<idx.
        for (int i = 0; i < VW; i++) begin
            applyStimulus(VW'(1) << i);
            checkOutput("onehot_roundtrip", 32'(VW'(1) << out_idx), 32'(VW'(1) << i));
            checkOutput("onehot_last", 32'(out_last), 32'd1);
            waitIdle(20, cycles);
            checkOutput("onehot_cycles", 32'(cycles), 32'd1);
        end

        // All bits set with a second vector waiting on in_valid throughout the drain.
        pushModel(16'hFFFF);
        in_valid = 1'b1;
        in_vec   = 16'hFFFF;
        @(posedge clk); #1;
        checkOutput("ffff_latency", 32'(out_valid), 32'd1);
        in_vec = 16'h0010;
        pushModel(16'h0010);
        n = 0;
        while (!in_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("ffff_drain_cycles", 32'(n), 32'd16);
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput("second_latency", 32'(out_valid), 32'd1);
        waitIdle(20, cycles);

        // Asynchronous reset mid-drain discards the remaining bits.
        base = beat_count;
        applyStimulus(16'h00FF);
        n = 0;
        while (beat_count < base + 2 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("pre_reset_beats", 32'(beat_count - base), 32'd2);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midreset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("midreset_out_idx", 32'(out_idx), 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        applyStimulus(16'h0100);
        checkOutput("post_reset_idx", 32'(out_idx), 32'd8);
        waitIdle(20, cycles);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("final_out_valid", 32'(out_valid), 32'd0);
        checkOutput("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout actual=running expected=finished");
        $fatal(1, "[TB] global timeout");
    end

endmodule
